// File: rtl/fmul_issue_arbiter.sv
// fmul_issue_arbiter
//   Round-robin issue arbiter in front of one shared pipelined fp32
//   multiplier. Requests are granted one per cycle. A {valid, id} tag
//   travels alongside the multiplier pipeline, so each result returns to
//   the requester that issued it. The whole pipe stalls through fmul_en
//   while the result at the tail is waiting to be accepted.
//
//   Optional build macro FMUL_ARB_PERF_EN adds the saturating performance
//   counters perf_issue, perf_stall and perf_busy.
//
//   Handshake: a request transfers on a cycle where req_valid[i] and
//   req_ready[i] are both 1. A result transfers on a cycle where
//   rsp_valid[i] and rsp_ready[i] are both 1. After rsp_valid rises, it
//   and rsp_data hold until that transfer. A requester may drop req_valid
//   before it is granted.
module fmul_issue_arbiter #(
  parameter int NREQ    = 2,
  parameter int LATENCY = 3,
  parameter int IDW     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [2*NREQ-1:0]    req_rm,
  output logic [31:0]          fmul_a,
  output logic [31:0]          fmul_b,
  output logic [1:0]           fmul_rm,
  output logic                 fmul_en,
  input  logic [31:0]          fmul_s,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_data
`ifdef FMUL_ARB_PERF_EN
  ,
  output logic [31:0]          perf_issue,
  output logic [31:0]          perf_stall,
  output logic [31:0]          perf_busy
`endif
);

  // Adds off to base and wraps the sum into [0, NREQ-1]. off is at most NREQ.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDW'(sum);
  endfunction

  logic [IDW-1:0]     ptr;
  logic               grant_valid;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     cand;
  logic [IDW-1:0]     sel_id;

  logic [LATENCY-1:0] tag_v;
  logic [IDW-1:0]     tag_id [LATENCY];
  logic               tail_v;
  logic [IDW-1:0]     tail_id;

  assign tail_v  = tag_v[LATENCY-1];
  assign tail_id = tag_id[LATENCY-1];

  // A valid result at the tail that nobody accepts freezes every stage.
  assign fmul_en = ~(tail_v & ~rsp_ready[tail_id]);

  // Round-robin search that starts at ptr. Nothing is granted while the pipe
  // is stalled or reset is held.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ptr;
    cand        = ptr;
    if (fmul_en && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = wrap_add(ptr, k);
        if (!grant_valid && req_valid[cand]) begin
          grant_valid = 1'b1;
          grant_id    = cand;
        end
      end
    end
  end

  // Drive a one-hot ready for the granted requester, or all zeros.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_valid && (grant_id == IDW'(i))) req_ready[i] = 1'b1;
    end
  end

  // The operand mux follows the grant. With no grant it parks on ptr, so the
  // multiplier inputs stay defined and stable.
  assign sel_id = grant_valid ? grant_id : ptr;

  // Select the operands and rounding mode of requester sel_id.
  always_comb begin
    fmul_a  = req_a[31:0];
    fmul_b  = req_b[31:0];
    fmul_rm = req_rm[1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (sel_id == IDW'(i)) begin
        fmul_a  = req_a[32*i +: 32];
        fmul_b  = req_b[32*i +: 32];
        fmul_rm = req_rm[2*i +: 2];
      end
    end
  end

  // After a grant, move the priority pointer to the slot after the winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= wrap_add(grant_id, 1);
    end
  end

  // Tag pipe. It advances in lockstep with the multiplier stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      for (int k = 0; k < LATENCY; k++) tag_id[k] <= '0;
    end else if (fmul_en) begin
      tag_v[0]  <= grant_valid;
      tag_id[0] <= grant_id;
      for (int k = 1; k < LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  // Route the tail result to the requester that issued it.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (tail_v && (tail_id == IDW'(i))) rsp_valid[i] = 1'b1;
    end
  end

  assign rsp_data = fmul_s;

`ifdef FMUL_ARB_PERF_EN
  // Saturating counters for issues, stalled cycles and occupied cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue <= '0;
      perf_stall <= '0;
      perf_busy  <= '0;
    end else begin
      if (grant_valid && (perf_issue != 32'hFFFF_FFFF)) perf_issue <= perf_issue + 32'd1;
      if (!fmul_en && (perf_stall != 32'hFFFF_FFFF))    perf_stall <= perf_stall + 32'd1;
      if ((|tag_v) && (perf_busy != 32'hFFFF_FFFF))     perf_busy  <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fmul_issue_arbiter.sv
// tb_fmul_issue_arbiter
//   Bench for fmul_issue_arbiter. A behavioural LATENCY-deep fp32 multiplier
//   sits on the fmul_* side. A reference arbiter/tag model predicts grants,
//   stalls and routing every cycle. The scoreboard queue holds
//   {id, product} from issue until delivery. Build with FMUL_ARB_PERF_EN
//   defined to also check the performance counters.
module tb_fmul_issue_arbiter;
  localparam int NREQ    = 2;
  localparam int LATENCY = 3;
  localparam int IDW     = 1;
  localparam int W       = IDW + 32;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [2*NREQ-1:0]    req_rm;
  logic [31:0]          fmul_a;
  logic [31:0]          fmul_b;
  logic [1:0]           fmul_rm;
  logic                 fmul_en;
  logic [31:0]          fmul_s;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [31:0]          rsp_data;
`ifdef FMUL_ARB_PERF_EN
  logic [31:0]          perf_issue;
  logic [31:0]          perf_stall;
  logic [31:0]          perf_busy;
`endif

  fmul_issue_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
    .fmul_a(fmul_a), .fmul_b(fmul_b), .fmul_rm(fmul_rm),
    .fmul_en(fmul_en), .fmul_s(fmul_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
`ifdef FMUL_ARB_PERF_EN
    , .perf_issue(perf_issue), .perf_stall(perf_stall), .perf_busy(perf_busy)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Truncating fp32 product. It is exact for the directed operands;
  // inf*0 gives the canonical quiet NaN.
  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic       s;
    logic [7:0] ea, eb;
    logic [47:0] p;
    int         e;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    if ((ea == 8'hFF && eb == 8'h00) || (eb == 8'hFF && ea == 8'h00)) return 32'h7FC0_0000;
    if (ea == 8'hFF || eb == 8'hFF) return {s, 8'hFF, 23'h0};
    if (ea == 8'h00 || eb == 8'h00) return {s, 31'h0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(ea) + int'(eb) - 127;
    if (p[47]) return {s, 8'(e + 1), p[46:24]};
    return {s, 8'(e), p[45:23]};
  endfunction

  // Behavioural multiplier. It shares the stage enable with the arbiter.
  logic [31:0] mul_pipe [LATENCY];
  always @(posedge clk) begin
    if (fmul_en) begin
      mul_pipe[0] <= fmul_ref(fmul_a, fmul_b);
      for (int k = 1; k < LATENCY; k++) mul_pipe[k] <= mul_pipe[k-1];
    end
  end
  assign fmul_s = mul_pipe[LATENCY-1];

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0] exp_q[$];
  bit m_v   [LATENCY];
  int m_id  [LATENCY];
  int m_ptr;
  bit n_v   [LATENCY];
  int n_id  [LATENCY];
  int n_ptr;
`ifdef FMUL_ARB_PERF_EN
  int c_issue, c_stall, c_busy;
`endif

  initial begin
    m_ptr = 0; n_ptr = 0;
    for (int k = 0; k < LATENCY; k++) begin m_v[k] = 0; m_id[k] = 0; n_v[k] = 0; n_id[k] = 0; end
`ifdef FMUL_ARB_PERF_EN
    c_issue = 0; c_stall = 0; c_busy = 0;
`endif
  end

  always @(posedge clk) begin
    if (!rst) begin
      m_v = n_v; m_id = n_id; m_ptr = n_ptr;
    end
  end

  always @(negedge clk) begin
    bit              e_en, gv, busy;
    int              gid, t;
    logic [NREQ-1:0] e_rv, e_rdy;
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) begin m_v[k] = 0; m_id[k] = 0; n_v[k] = 0; n_id[k] = 0; end
      m_ptr = 0; n_ptr = 0;
      exp_q.delete();
      check("rst_req_ready", 64'(req_ready), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_fmul_en", 64'(fmul_en), 64'(1));
      check("rst_fmul_a", 64'(fmul_a), 64'(req_a[31:0]));
`ifdef FMUL_ARB_PERF_EN
      c_issue = 0; c_stall = 0; c_busy = 0;
`endif
    end else begin
      e_en = !(m_v[LATENCY-1] && !rsp_ready[m_id[LATENCY-1]]);
      e_rv = '0;
      if (m_v[LATENCY-1]) e_rv[m_id[LATENCY-1]] = 1'b1;
      gv = 0; gid = m_ptr;
      if (e_en) begin
        for (int k = 0; k < NREQ; k++) begin
          t = (m_ptr + k) % NREQ;
          if (!gv && req_valid[t]) begin gv = 1; gid = t; end
        end
      end
      e_rdy = '0;
      if (gv) e_rdy[gid] = 1'b1;
      check("fmul_en", 64'(fmul_en), 64'(e_en));
      check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      check("req_ready", 64'(req_ready), 64'(e_rdy));
      if (gv) begin
        check("fmul_a", 64'(fmul_a), 64'(req_a[gid*32 +: 32]));
        check("fmul_b", 64'(fmul_b), 64'(req_b[gid*32 +: 32]));
        check("fmul_rm", 64'(fmul_rm), 64'(req_rm[gid*2 +: 2]));
        exp_q.push_back({IDW'(gid), fmul_ref(req_a[gid*32 +: 32], req_b[gid*32 +: 32])});
      end
      if (m_v[LATENCY-1]) begin
        if (exp_q.size() == 0) check("sb_underflow", 64'(exp_q.size()), 64'(1));
        else begin
          check("sb_data", 64'(rsp_data), 64'(exp_q[0][31:0]));
          if (rsp_ready[m_id[LATENCY-1]]) void'(exp_q.pop_front());
        end
      end
`ifdef FMUL_ARB_PERF_EN
      check("perf_issue", 64'(perf_issue), 64'(c_issue));
      check("perf_stall", 64'(perf_stall), 64'(c_stall));
      check("perf_busy", 64'(perf_busy), 64'(c_busy));
      busy = 0;
      for (int k = 0; k < LATENCY; k++) if (m_v[k]) busy = 1;
      if (gv) c_issue++;
      if (!e_en) c_stall++;
      if (busy) c_busy++;
`endif
      n_v = m_v; n_id = m_id; n_ptr = m_ptr;
      if (e_en) begin
        for (int k = LATENCY - 1; k > 0; k--) begin n_v[k] = m_v[k-1]; n_id[k] = m_id[k-1]; end
        n_v[0] = gv; n_id[0] = gid;
      end
      if (gv) n_ptr = (gid + 1) % NREQ;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_rm[i*2 +: 2]  = rm;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Wait, up to a bounded number of cycles, for a negedge with any rsp_valid.
  task automatic wait_rsp(input string tag, output int cycles);
    cycles = 0;
    while (rsp_valid == '0 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    if (rsp_valid == '0) check(tag, 64'(0), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] bp_a [3];
  logic [31:0] bp_r [3];
  int cyc, nrsp;

  initial begin
    bp_a[0] = 32'h3F80_0000; bp_a[1] = 32'h4000_0000; bp_a[2] = 32'h4040_0000;
    bp_r[0] = 32'h3F80_0000; bp_r[1] = 32'h4080_0000; bp_r[2] = 32'h4110_0000;
    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_rm = '0; rsp_ready = '1;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single issue: the result arrives exactly LATENCY cycles after the grant
    @(posedge clk); #1;
    set_req(0, 32'h3F80_0000, 32'h4000_0000, 2'd0);
    req_valid = 2'b01;
    @(negedge clk);
    check("t1_grant", 64'(req_ready), 64'(2'b01));
    @(posedge clk); #1;
    req_valid = '0;
    cyc = 0;
    repeat (LATENCY + 3) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid != '0) break;
    end
    check("t1_latency", 64'(cyc), 64'(LATENCY));
    check("t1_rsp_valid", 64'(rsp_valid), 64'(2'b01));
    check("t1_rsp_data", 64'(rsp_data), 64'(32'h4000_0000));
    repeat (3) @(posedge clk);

    // contention: grants alternate starting with requester 0 after reset
    do_reset();
    set_req(0, 32'h4040_0000, 32'h4000_0000, 2'd1);
    set_req(1, 32'h3FC0_0000, 32'h3FC0_0000, 2'd2);
    nrsp = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      req_valid = (c < 8) ? 2'b11 : 2'b00;
      @(negedge clk);
      if (c < 8) check("t2_grant", 64'(req_ready), 64'((c % 2 == 0) ? 2'b01 : 2'b10));
      if (rsp_valid != '0) begin
        check("t2_rsp_valid", 64'(rsp_valid), 64'((nrsp % 2 == 0) ? 2'b01 : 2'b10));
        check("t2_rsp_data", 64'(rsp_data), 64'((nrsp % 2 == 0) ? 32'h40C0_0000 : 32'h4010_0000));
        nrsp++;
      end
    end
    check("t2_rsp_count", 64'(nrsp), 64'(8));

    // backpressure: tail result held, pipe frozen, then the queued results drain back-to-back
    do_reset();
    rsp_ready = 2'b10;
    for (int k = 0; k < 3; k++) begin
      set_req(0, bp_a[k], bp_a[k], 2'd0);
      req_valid = 2'b01;
      @(posedge clk); #1;
    end
    set_req(1, 32'h4000_0000, 32'h4000_0000, 2'd3);
    req_valid = 2'b10;
    wait_rsp("t3_timeout", cyc);
    for (int h = 0; h < 5; h++) begin
      check("t3_hold_valid", 64'(rsp_valid), 64'(2'b01));
      check("t3_hold_data", 64'(rsp_data), 64'(32'h3F80_0000));
      check("t3_hold_en", 64'(fmul_en), 64'(0));
      check("t3_hold_ready", 64'(req_ready), 64'(0));
      @(posedge clk); #1;
      if (h < 4) @(negedge clk);
    end
    rsp_ready = '1;
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_drain_valid", 64'(rsp_valid), 64'(2'b01));
      check("t3_drain_data", 64'(rsp_data), 64'(bp_r[k]));
    end
    repeat (4) @(posedge clk);

    // special operands: inf * 0 through requester 1
    #1;
    set_req(1, 32'h7F80_0000, 32'h0000_0000, 2'd0);
    req_valid = 2'b10;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    wait_rsp("t4_timeout", cyc);
    check("t4_rsp_valid", 64'(rsp_valid), 64'(2'b10));
    check("t4_nan_exp", 64'(rsp_data[30:23]), 64'(8'hFF));
    check("t4_nan_frac_nz", 64'(rsp_data[22:0] != 23'h0), 64'(1));
    repeat (3) @(posedge clk);

    // reset mid-flight: in-flight ops vanish, and ptr is back at 0
    do_reset();
    set_req(0, 32'h4000_0000, 32'h4040_0000, 2'd0);
    req_valid = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < LATENCY + 2; c++) begin
      @(negedge clk);
      check("t5_no_rsp", 64'(rsp_valid), 64'(0));
    end
    @(posedge clk); #1;
    set_req(1, 32'h3F80_0000, 32'h4040_0000, 2'd0);
    req_valid = 2'b10;
    @(negedge clk);
    check("t5_grant_req1", 64'(req_ready), 64'(2'b10));
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    check("t5_ptr_wrap", 64'(req_ready), 64'(2'b01));
    @(posedge clk); #1;
    req_valid = '0;

    // random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, $urandom, $urandom, 2'($urandom_range(0, 3)));
        req_valid[i] = ($urandom_range(0, 2) != 0);
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = '1;
    repeat (2 * LATENCY + 4) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit, in case any wait above fails to end.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
